// File: rtl/encoder4e_pkg.sv
// Shared types and the priority-search helper for the encoder4e family.
// Optional build macro ENCODER4E_ROUND_ROBIN_EN is consumed by encoder4e_seq.
package encoder4e_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int MAX_N = 64;
  localparam int MAX_W = 6;

  typedef struct packed {
    logic             found;
    logic [MAX_W-1:0] idx;
  } prio_t;

  // First set bit of pend searched downward from start, wrapping within n lines.
  function automatic prio_t prio_sel(input logic [MAX_N-1:0] pend,
                                     input logic [MAX_W-1:0] start,
                                     input int               n);
    prio_t            r;
    logic [MAX_W-1:0] i;
    r = '0;
    for (int k = 0; k < MAX_N; k++) begin
      i = (start - MAX_W'(k)) & MAX_W'(n - 1);
      if ((k < n) && !r.found && pend[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder4e_prio.sv
// Combinational N-to-CODE_W priority selector with a wrap-around start index.
module encoder4e_prio
  import encoder4e_pkg::*;
#(
  parameter int N      = 4,
  parameter int CODE_W = $clog2(N)
) (
  input  logic [N-1:0]      req,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  logic [MAX_N-1:0] req_ext;
  prio_t            sel;
  prio_t            unused_sel;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_N; gi++) begin : g_ext
      if (gi < N) begin : g_live
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign sel        = prio_sel(req_ext, MAX_W'(start), N);
  assign unused_sel = sel;
  assign idx        = sel.idx[CODE_W-1:0];
  assign found      = sel.found;

endmodule

// File: rtl/encoder4e_seq.sv
// Registered priority encoder: latches request pulses, emits one code per valid/ready transfer.
// Define ENCODER4E_ROUND_ROBIN_EN for rotating priority instead of fixed highest-index-first.
module encoder4e_seq
  import encoder4e_pkg::*;
#(
  parameter int N      = 4,
  parameter int CODE_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      in,
  input  logic              enable,
  output logic [CODE_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      pending,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [N-1:0]      pending_reg, pending_next;
  logic [N-1:0]      grant_mask, set_mask;
  logic [CODE_W-1:0] out_reg, out_next;
  logic [CODE_W-1:0] cand, start;
  logic              found, load;

`ifdef ENCODER4E_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_reg;

  assign start = last_reg - CODE_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_reg <= CODE_W'(N - 1);
    end else if (load) begin
      last_reg <= cand;
    end
  end
`else
  assign start = CODE_W'(N - 1);
`endif

  encoder4e_prio #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_prio (
    .req   (pending_reg),
    .start (start),
    .idx   (cand),
    .found (found)
  );

  assign load = found && ((state_reg == EMPTY) || out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant_mask[gi] = load && (cand == CODE_W'(gi));
    end
  endgenerate

  // New requests are OR-ed after the grant clear so a same-cycle re-request survives.
  assign set_mask     = enable ? in : '0;
  assign pending_next = (pending_reg & ~grant_mask) | set_mask;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    case (state_reg)
      EMPTY: begin
        if (load) begin
          out_next   = cand;
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (load) begin
            out_next = cand;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= EMPTY;
      pending_reg <= '0;
      out_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      out_reg     <= out_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = (state_reg == FULL);
  assign pending   = pending_reg;
  assign busy      = out_valid | (|pending_reg);

endmodule

// File: tb/tb_encoder4e_seq.sv
// Self-checking bench for encoder4e_seq: directed table, reset/round-robin sequences, random vs model.
module tb_encoder4e_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_s = 4'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] out_s;
  logic       out_valid;
  logic [3:0] pending;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  encoder4e_seq #(.N(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in_s),
    .enable    (enable),
    .out       (out_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .busy      (busy)
  );

  // Reference model: a set of pending indices plus a one-entry output slot.
  bit m_pend[4];
  int m_out;
  bit m_valid;
  int m_last;

  function automatic int pick();
`ifdef ENCODER4E_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last - k + 8) % 4;
      if (m_pend[i]) return i;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (m_pend[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_out   = 0;
    m_valid = 1'b0;
    m_last  = 3;
  endtask

  task automatic model_step(input logic [3:0] i_in, input logic i_en, input logic i_rdy);
    int c;
    c = pick();
    if ((!m_valid || i_rdy) && c >= 0) begin
      m_out     = c;
      m_valid   = 1'b1;
      m_pend[c] = 1'b0;
      m_last    = c;
    end else if (m_valid && i_rdy) begin
      m_valid = 1'b0;
    end
    if (i_en) begin
      for (int i = 0; i < 4; i++) if (i_in[i]) m_pend[i] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pending"}, int'(pending), int'(m_pend_vec()));
    chk({tag, "_valid"}, int'(out_valid), int'(m_valid));
    chk({tag, "_out"}, int'(out_s), m_out);
    chk({tag, "_busy"}, int'(busy), int'(m_valid || (m_pend_vec() != 4'b0)));
  endtask

  task automatic cycle(input logic [3:0] i_in, input logic i_en, input logic i_rdy, input string tag);
    in_s      = i_in;
    enable    = i_en;
    out_ready = i_rdy;
    @(posedge clk);
    model_step(i_in, i_en, i_rdy);
    #1;
    check_model(tag);
    $display("cyc %s in=%b en=%b rdy=%b -> pend=%b valid=%b out=%0d", tag, i_in, i_en, i_rdy,
             pending, out_valid, out_s);
  endtask

  typedef struct {
    logic [3:0] in;
    logic       en;
    logic       rdy;
    logic [3:0] pend;
    logic       vld;
    logic [1:0] out;
  } vec_t;

  vec_t tbl[21];

`ifdef ENCODER4E_ROUND_ROBIN_EN
  localparam logic [3:0] P1 = 4'b1000;
  localparam logic [1:0] A1 = 2'd1;
  localparam logic [1:0] A2 = 2'd3;
`else
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [1:0] A1 = 2'd3;
  localparam logic [1:0] A2 = 2'd1;
`endif

  initial begin
    int prev;
    logic [3:0] r_in;

    tbl[0]  = '{4'b1010, 1'b1, 1'b1, 4'b1010, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b1, P1,      1'b1, A1};
    tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, A2};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, A2};
    tbl[4]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, A2};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, A2};
    tbl[6]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, A2};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[9]  = '{4'b1100, 1'b1, 1'b0, 4'b1100, 1'b0, 2'd0};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd3};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd3};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd3};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd3};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd3};
    tbl[15] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[17] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd2};
    tbl[18] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[19] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[20] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pending", int'(pending), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_out", int'(out_s), 0);
    chk("reset_busy", int'(busy), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 21; v++) begin
      cycle(tbl[v].in, tbl[v].en, tbl[v].rdy, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d_exp_pending", v), int'(pending), int'(tbl[v].pend));
      chk($sformatf("tbl%0d_exp_valid", v), int'(out_valid), int'(tbl[v].vld));
      chk($sformatf("tbl%0d_exp_out", v), int'(out_s), int'(tbl[v].out));
    end

    // Asynchronous reset while a code is held and two requests are pending.
    cycle(4'b0110, 1'b1, 1'b0, "ar0");
    cycle(4'b0100, 1'b1, 1'b0, "ar1");
    chk("ar_pre_pending", int'(pending), 6);
    chk("ar_pre_valid", int'(out_valid), 1);
    chk("ar_pre_out", int'(out_s), 2);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_pending", int'(pending), 0);
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_out", int'(out_s), 0);
    $display("async reset mid-cycle: pend=%b valid=%b busy=%b", pending, out_valid, busy);
    model_reset();
    #2 reset_n = 1'b1;

    // All four lines held: rotating order in the round-robin build, constant 3 otherwise.
    prev = 0;
    for (int j = 0; j < 8; j++) begin
      cycle(4'b1111, 1'b1, 1'b1, $sformatf("rr%0d", j));
      if (j >= 1) begin
        chk($sformatf("rr%0d_valid", j), int'(out_valid), 1);
`ifdef ENCODER4E_ROUND_ROBIN_EN
        if (j >= 2) chk($sformatf("rr%0d_order", j), int'(out_s), (prev + 3) % 4);
`else
        chk($sformatf("rr%0d_fixed", j), int'(out_s), 3);
`endif
        prev = int'(out_s);
      end
    end
    for (int j = 0; j < 6; j++) cycle(4'b0000, 1'b0, 1'b1, $sformatf("drain%0d", j));

    for (int j = 0; j < 400; j++) begin
      r_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle(r_in, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
            $sformatf("rnd%0d", j));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
